trace_capture_buffer: RTL and testbench

- Parametrised trace memory with an integrated capture controller. Successor to the fixed 64x8192 trace RAM.
- Captures a data stream in linear (stop-when-full) or circular (pre/post-trigger) mode, then offers a registered, relative-addressed readout.
- Sits between the emulation probe mux and the control/verification readout logic. Single clock domain.

---
 rtl/trace_capture_buffer.sv | 176 +++++++++++++++++
 tb/tb_trace_capture_buffer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/trace_capture_buffer.sv
// rtl/trace_capture_buffer.sv - trace memory with linear/circular capture control
// Readout is relative to the oldest retained sample and registered with one cycle latency.
module trace_capture_buffer #(
  parameter int DATA_WIDTH  = 64,
  parameter int ADDR_WIDTH  = 13,
  parameter int FULL_MARGIN = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  din_valid,
  input  logic                  arm,
  input  logic                  trigger,
  input  logic                  mode,
  input  logic [ADDR_WIDTH-1:0] post_count,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  output logic [1:0]            state,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   capture_len,
  output logic [ADDR_WIDTH-1:0] trig_index
);

  localparam int DEPTH     = 1 << ADDR_WIDTH;
  localparam int AF_THRESH = DEPTH - FULL_MARGIN;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ARMED = 2'd1;
  localparam logic [1:0] S_POST  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic                  wrapped_q, wrapped_d;
  logic                  mode_q, mode_d;
  logic [ADDR_WIDTH-1:0] trig_phys_q, trig_phys_d;
  logic [ADDR_WIDTH-1:0] remaining_q, remaining_d;
  logic                  trig_hit_q, trig_hit_d;
  logic                  trig_wr_q, trig_wr_d;
  logic [ADDR_WIDTH:0]   capture_len_q, capture_len_d;
  logic [ADDR_WIDTH-1:0] trig_index_q, trig_index_d;
  logic [ADDR_WIDTH-1:0] start_q, start_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  dout_valid_q, dout_valid_d;

  logic                  mem_we;
  logic                  done_entry;
  logic [ADDR_WIDTH-1:0] rd_phys;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      wr_ptr_q      <= '0;
      wrapped_q     <= 1'b0;
      mode_q        <= 1'b0;
      trig_phys_q   <= '0;
      remaining_q   <= '0;
      trig_hit_q    <= 1'b0;
      trig_wr_q     <= 1'b0;
      capture_len_q <= '0;
      trig_index_q  <= '0;
      start_q       <= '0;
      dout_q        <= '0;
      dout_valid_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      wrapped_q     <= wrapped_d;
      mode_q        <= mode_d;
      trig_phys_q   <= trig_phys_d;
      remaining_q   <= remaining_d;
      trig_hit_q    <= trig_hit_d;
      trig_wr_q     <= trig_wr_d;
      capture_len_q <= capture_len_d;
      trig_index_q  <= trig_index_d;
      start_q       <= start_d;
      dout_q        <= dout_d;
      dout_valid_q  <= dout_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_ptr_q] <= din;
    end
  end

  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    wrapped_d     = wrapped_q;
    mode_d        = mode_q;
    trig_phys_d   = trig_phys_q;
    remaining_d   = remaining_q;
    trig_hit_d    = trig_hit_q;
    trig_wr_d     = trig_wr_q;
    capture_len_d = capture_len_q;
    trig_index_d  = trig_index_q;
    start_d       = start_q;
    dout_d        = dout_q;
    dout_valid_d  = 1'b0;
    mem_we        = 1'b0;
    done_entry    = 1'b0;
    rd_phys       = start_q + rd_addr;

    if (arm) begin
      wr_ptr_d    = '0;
      wrapped_d   = 1'b0;
      mode_d      = mode;
      trig_hit_d  = 1'b0;
      trig_wr_d   = 1'b0;
      remaining_d = '0;
      state_d     = S_ARMED;
    end else begin
      case (state_q)
        S_ARMED, S_POST: begin
          if (din_valid) begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
            if (wr_ptr_q == LAST_ADDR) wrapped_d = 1'b1;
          end
          if (state_q == S_ARMED) begin
            if (trigger) begin
              trig_hit_d  = 1'b1;
              trig_phys_d = wr_ptr_q;
              remaining_d = post_count;
              trig_wr_d   = din_valid;
              if (post_count == '0 && din_valid) done_entry = 1'b1;
              else state_d = S_POST;
            end
          end else if (din_valid) begin
            // A trigger without a same-cycle sample claims the next written sample.
            if (!trig_wr_q) begin
              trig_wr_d = 1'b1;
              if (remaining_q == '0) done_entry = 1'b1;
            end else begin
              remaining_d = remaining_q - ADDR_WIDTH'(1);
              if (remaining_q == ADDR_WIDTH'(1)) done_entry = 1'b1;
            end
          end
          if (!mode_q && din_valid && wr_ptr_q == LAST_ADDR) done_entry = 1'b1;
          if (done_entry) begin
            state_d       = S_DONE;
            capture_len_d = wrapped_d ? (ADDR_WIDTH+1)'(DEPTH) : {1'b0, wr_ptr_d};
            start_d       = wrapped_d ? wr_ptr_d : '0;
            trig_index_d  = trig_hit_d ? (trig_phys_d - start_d) : '0;
          end
        end
        S_DONE: begin
          if (rd_en) begin
            dout_valid_d = 1'b1;
            dout_d = ({1'b0, rd_addr} < capture_len_q) ? mem[rd_phys] : '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state       = state_q;
    dout        = dout_q;
    dout_valid  = dout_valid_q;
    capture_len = capture_len_q;
    trig_index  = trig_index_q;
    almost_full = (state_q == S_ARMED || state_q == S_POST) && !mode_q &&
                  (int'(wr_ptr_q) >= AF_THRESH);
  end

endmodule

// File: tb/tb_trace_capture_buffer.sv
// tb/tb_trace_capture_buffer.sv - directed bench for trace_capture_buffer
module tb_trace_capture_buffer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] din;
  logic       din_valid;
  logic       arm;
  logic       trigger;
  logic       mode;
  logic [3:0] post_count;
  logic       rd_en;
  logic [3:0] rd_addr;
  logic [7:0] dout;
  logic       dout_valid;
  logic [1:0] state;
  logic       almost_full;
  logic [4:0] capture_len;
  logic [3:0] trig_index;

  int n_cmp  = 0;
  int n_fail = 0;

  trace_capture_buffer #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FULL_MARGIN(10)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .arm(arm),
    .trigger(trigger), .mode(mode), .post_count(post_count), .rd_en(rd_en),
    .rd_addr(rd_addr), .dout(dout), .dout_valid(dout_valid), .state(state),
    .almost_full(almost_full), .capture_len(capture_len), .trig_index(trig_index)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_arm(input logic m);
    mode = m; arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic do_read(input logic [3:0] a);
    rd_en = 1'b1; rd_addr = a;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; din = '0; din_valid = 0; arm = 0; trigger = 0; mode = 0;
    post_count = '0; rd_en = 0; rd_addr = '0;
    tick(); tick();
    n_cmp++; if (state !== 2'd0) begin n_fail++; $display("FAIL reset_state got %0d want 0", state); end
    n_cmp++; if (dout !== 8'h00 || dout_valid !== 1'b0) begin n_fail++; $display("FAIL reset_dout got %0h/%0b want 0/0", dout, dout_valid); end
    n_cmp++; if (capture_len !== 5'd0 || trig_index !== 4'd0 || almost_full !== 1'b0) begin n_fail++; $display("FAIL reset_misc got %0d/%0d/%0b want 0/0/0", capture_len, trig_index, almost_full); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_linear();
    do_arm(1'b0);
    n_cmp++; if (state !== 2'd1) begin n_fail++; $display("FAIL lin_armed got %0d want 1", state); end
    for (int i = 0; i < 16; i++) begin
      din = 8'(i); din_valid = 1'b1;
      tick();
      n_cmp++; if (almost_full !== (i >= 5 && i < 15)) begin n_fail++; $display("FAIL lin_af[%0d] got %0b want %0b", i, almost_full, (i >= 5 && i < 15)); end
      n_cmp++; if (state !== ((i == 15) ? 2'd3 : 2'd1)) begin n_fail++; $display("FAIL lin_state[%0d] got %0d want %0d", i, state, (i == 15) ? 3 : 1); end
    end
    din_valid = 1'b0;
    n_cmp++; if (capture_len !== 5'd16 || trig_index !== 4'd0) begin n_fail++; $display("FAIL lin_len got %0d/%0d want 16/0", capture_len, trig_index); end
    for (int i = 0; i < 16; i++) begin
      rd_en = 1'b1; rd_addr = 4'(i);
      tick();
      n_cmp++; if (dout_valid !== 1'b1 || dout !== 8'(i)) begin n_fail++; $display("FAIL lin_rd[%0d] got %0h/%0b want %0h/1", i, dout, dout_valid, i); end
    end
    rd_en = 1'b0;
    tick();
    n_cmp++; if (dout_valid !== 1'b0 || dout !== 8'h0F) begin n_fail++; $display("FAIL lin_rd_idle got %0h/%0b want 0f/0", dout, dout_valid); end
  endtask

  task automatic test_circular_wrap();
    logic [1:0] exp_st;
    do_arm(1'b1);
    post_count = 4'd4;
    for (int i = 0; i <= 8'h24; i++) begin
      din = 8'(i); din_valid = 1'b1; trigger = (i == 8'h20);
      tick();
      exp_st = (i < 8'h20) ? 2'd1 : (i < 8'h24) ? 2'd2 : 2'd3;
      if (i >= 8'h1F) begin
        n_cmp++; if (state !== exp_st) begin n_fail++; $display("FAIL circ_state[%0h] got %0d want %0d", i, state, exp_st); end
      end
      n_cmp++; if (almost_full !== 1'b0) begin n_fail++; $display("FAIL circ_af[%0h] got %0b want 0", i, almost_full); end
    end
    din_valid = 1'b0; trigger = 1'b0;
    n_cmp++; if (capture_len !== 5'd16 || trig_index !== 4'd11) begin n_fail++; $display("FAIL circ_len got %0d/%0d want 16/11", capture_len, trig_index); end
    do_read(4'd0);
    n_cmp++; if (dout !== 8'h15 || dout_valid !== 1'b1) begin n_fail++; $display("FAIL circ_rd0 got %0h/%0b want 15/1", dout, dout_valid); end
    do_read(4'd11);
    n_cmp++; if (dout !== 8'h20 || dout_valid !== 1'b1) begin n_fail++; $display("FAIL circ_rd11 got %0h/%0b want 20/1", dout, dout_valid); end
    do_read(4'd15);
    n_cmp++; if (dout !== 8'h24 || dout_valid !== 1'b1) begin n_fail++; $display("FAIL circ_rd15 got %0h/%0b want 24/1", dout, dout_valid); end
  endtask

  task automatic test_post_zero();
    do_arm(1'b1);
    post_count = 4'd0;
    for (int i = 0; i < 8; i++) begin
      din = 8'(i); din_valid = 1'b1; trigger = (i == 7);
      tick();
    end
    din_valid = 1'b0; trigger = 1'b0;
    n_cmp++; if (state !== 2'd3) begin n_fail++; $display("FAIL pz_state got %0d want 3", state); end
    n_cmp++; if (capture_len !== 5'd8 || trig_index !== 4'd7) begin n_fail++; $display("FAIL pz_len got %0d/%0d want 8/7", capture_len, trig_index); end
    do_read(4'd7);
    n_cmp++; if (dout !== 8'h07 || dout_valid !== 1'b1) begin n_fail++; $display("FAIL pz_rd got %0h/%0b want 07/1", dout, dout_valid); end
  endtask

  task automatic test_short();
    do_arm(1'b1);
    post_count = 4'd2;
    for (int i = 0; i < 5; i++) begin
      din = 8'hA0 + 8'(i); din_valid = 1'b1; trigger = (i == 2);
      tick();
    end
    din_valid = 1'b0; trigger = 1'b0;
    n_cmp++; if (state !== 2'd3) begin n_fail++; $display("FAIL short_state got %0d want 3", state); end
    n_cmp++; if (capture_len !== 5'd5 || trig_index !== 4'd2) begin n_fail++; $display("FAIL short_len got %0d/%0d want 5/2", capture_len, trig_index); end
    do_read(4'd2);
    n_cmp++; if (dout !== 8'hA2 || dout_valid !== 1'b1) begin n_fail++; $display("FAIL short_rd2 got %0h/%0b want a2/1", dout, dout_valid); end
    do_read(4'd7);
    n_cmp++; if (dout !== 8'h00 || dout_valid !== 1'b1) begin n_fail++; $display("FAIL short_rd7 got %0h/%0b want 00/1", dout, dout_valid); end
    do_read(4'd4);
    n_cmp++; if (dout !== 8'hA4 || dout_valid !== 1'b1) begin n_fail++; $display("FAIL short_rd4 got %0h/%0b want a4/1", dout, dout_valid); end
  endtask

  task automatic test_gaps_priority();
    mode = 1'b1; arm = 1'b1; trigger = 1'b1;
    tick();
    arm = 1'b0; trigger = 1'b0;
    n_cmp++; if (state !== 2'd1) begin n_fail++; $display("FAIL prio_state got %0d want 1", state); end
    do_read(4'd0);
    n_cmp++; if (dout_valid !== 1'b0 || dout !== 8'hA4) begin n_fail++; $display("FAIL armed_rd got %0h/%0b want a4/0", dout, dout_valid); end
    for (int i = 0; i < 3; i++) begin
      din = 8'hB0 + 8'(i); din_valid = 1'b1;
      tick();
    end
    n_cmp++; if (state !== 2'd1) begin n_fail++; $display("FAIL prio_no_trig got %0d want 1", state); end
    post_count = 4'd3; din = 8'h50; trigger = 1'b1;
    tick();
    trigger = 1'b0; din = 8'h51;
    tick();
    din_valid = 1'b0;
    tick(); tick(); tick();
    n_cmp++; if (state !== 2'd2) begin n_fail++; $display("FAIL gap_post got %0d want 2", state); end
    din = 8'h52; din_valid = 1'b1;
    tick();
    n_cmp++; if (state !== 2'd2) begin n_fail++; $display("FAIL gap_post2 got %0d want 2", state); end
    din = 8'h53;
    tick();
    din_valid = 1'b0;
    n_cmp++; if (state !== 2'd3) begin n_fail++; $display("FAIL gap_done got %0d want 3", state); end
    n_cmp++; if (capture_len !== 5'd7 || trig_index !== 4'd3) begin n_fail++; $display("FAIL gap_len got %0d/%0d want 7/3", capture_len, trig_index); end
    do_read(4'd6);
    n_cmp++; if (dout !== 8'h53 || dout_valid !== 1'b1) begin n_fail++; $display("FAIL gap_rd6 got %0h/%0b want 53/1", dout, dout_valid); end
  endtask

  task automatic test_reset_mid_post();
    do_arm(1'b1);
    post_count = 4'd5;
    din = 8'h60; din_valid = 1'b1; trigger = 1'b1;
    tick();
    trigger = 1'b0; din = 8'h61;
    tick();
    din_valid = 1'b0;
    n_cmp++; if (state !== 2'd2) begin n_fail++; $display("FAIL rst_pre_post got %0d want 2", state); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (state !== 2'd0 || capture_len !== 5'd0) begin n_fail++; $display("FAIL rst_async got %0d/%0d want 0/0", state, capture_len); end
    n_cmp++; if (dout !== 8'h00 || dout_valid !== 1'b0) begin n_fail++; $display("FAIL rst_async_dout got %0h/%0b want 0/0", dout, dout_valid); end
    #1 rst = 1'b0;
    do_read(4'd0);
    n_cmp++; if (dout_valid !== 1'b0 || dout !== 8'h00 || state !== 2'd0) begin n_fail++; $display("FAIL rst_rd got %0h/%0b/%0d want 0/0/0", dout, dout_valid, state); end
  endtask

  initial begin
    test_reset();
    test_linear();
    test_circular_wrap();
    test_post_zero();
    test_short();
    test_gaps_priority();
    test_reset_mid_post();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
